// File: rtl/axi_lite_intr_pkg.sv
// Shared register offsets, response codes and FSM state types for axi_lite_intr_ctrl.
package axi_lite_intr_pkg;

  localparam logic [4:0] OffGie  = 5'h00;
  localparam logic [4:0] OffIer  = 5'h04;
  localparam logic [4:0] OffIsr  = 5'h08;
  localparam logic [4:0] OffIar  = 5'h0C;
  localparam logic [4:0] OffIpr  = 5'h10;
  localparam logic [4:0] OffMode = 5'h14;

  localparam logic [1:0] RespOkay = 2'b00;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [31:0] strb_merge(logic [31:0] old_val, logic [31:0] new_val,
                                             logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/axi_lite_intr_ctrl_src_cell.sv
// One interrupt source: optional two-flop synchroniser (INTR_SYNC_EN), edge detect and ISR bit.
module intr_src_cell
  import axi_lite_intr_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic intr_i,
  input  logic edge_mode_i,
  input  logic clr_i,
  output logic isr_o
);

  logic src;
  logic hist_q;
  logic isr_q, isr_d;
  logic set;

`ifdef INTR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], intr_i};
    end
  end

  assign src = sync_q[1];
`else
  assign src = intr_i;
`endif

  // A set on the same edge as a clear wins; level sources re-set while high.
  always_comb begin
    set   = edge_mode_i ? (src & ~hist_q) : src;
    isr_d = set | (isr_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 1'b0;
      isr_q  <= 1'b0;
    end else begin
      hist_q <= src;
      isr_q  <= isr_d;
    end
  end

  assign isr_o = isr_q;

endmodule

// File: rtl/axi_lite_intr_ctrl.sv
// AXI4-Lite interrupt controller for up to 32 sources with edge/level capture and irq output.
// Define INTR_SYNC_EN to pass each intr bit through a two-flop synchroniser.
module axi_lite_intr_ctrl
  import axi_lite_intr_pkg::*;
#(
  parameter int unsigned C_NUM_INTR         = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_IRQ_SENSITIVITY  = 1,
  parameter int unsigned C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_NUM_INTR-1:0]         intr,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          irq
);

  localparam logic IrqActive = 1'(C_IRQ_ACTIVE_STATE);

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  gie_q, gie_d;
  logic [C_NUM_INTR-1:0] ier_q, ier_d;
  logic [C_NUM_INTR-1:0] mode_q, mode_d;
  logic [C_NUM_INTR-1:0] isr, ipr, iar_clr;
  logic [31:0]           rdata_q, rdata_d, rd_word;
  logic [31:0]           gie_wr, ier_wr, mode_wr, clr_wr;
  logic [4:0]            wr_addr, rd_addr;
  logic                  wr_en, rd_en;
  logic                  pend_any, pend_q;
  logic                  irq_q, irq_d, irq_set;
  logic                  unused_sigs;

  assign wr_addr = {S_AXI_AWADDR[4:2], 2'b00};
  assign rd_addr = {S_AXI_ARADDR[4:2], 2'b00};

  // Handshake outputs are held low while reset is asserted.
  assign wr_en = ARESETN & (w_state_q == WIdle) & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en = ARESETN & (r_state_q == RIdle) & S_AXI_ARVALID;

  assign gie_wr  = strb_merge({31'b0, gie_q}, S_AXI_WDATA, S_AXI_WSTRB);
  assign ier_wr  = strb_merge(32'(ier_q), S_AXI_WDATA, S_AXI_WSTRB);
  assign mode_wr = strb_merge(32'(mode_q), S_AXI_WDATA, S_AXI_WSTRB);
  assign clr_wr  = strb_merge(32'h0, S_AXI_WDATA, S_AXI_WSTRB);

  always_comb begin
    w_state_d = w_state_q;
    gie_d     = gie_q;
    ier_d     = ier_q;
    mode_d    = mode_q;
    iar_clr   = '0;
    unique case (w_state_q)
      WIdle: begin
        if (wr_en) begin
          w_state_d = WResp;
          case (wr_addr)
            OffGie:  gie_d   = gie_wr[0];
            OffIer:  ier_d   = ier_wr[C_NUM_INTR-1:0];
            OffIar:  iar_clr = clr_wr[C_NUM_INTR-1:0];
            OffMode: mode_d  = mode_wr[C_NUM_INTR-1:0];
            default: ;
          endcase
        end
      end
      WResp: begin
        if (S_AXI_BREADY) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (rd_addr)
      OffGie:  rd_word[0] = gie_q;
      OffIer:  rd_word    = 32'(ier_q);
      OffIsr:  rd_word    = 32'(isr);
      OffIpr:  rd_word    = 32'(ipr);
      OffMode: rd_word    = 32'(mode_q);
      default: rd_word    = '0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        if (rd_en) begin
          r_state_d = RData;
          rdata_d   = rd_word;
        end
      end
      RData: begin
        if (S_AXI_RREADY) begin
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  for (genvar i = 0; i < C_NUM_INTR; i++) begin : g_src
    intr_src_cell u_cell (
      .clk_i       (ACLK),
      .rst_ni      (ARESETN),
      .intr_i      (intr[i]),
      .edge_mode_i (mode_q[i]),
      .clr_i       (iar_clr[i]),
      .isr_o       (isr[i])
    );
  end

  assign ipr      = isr & ier_q;
  assign pend_any = gie_q & (|ipr);

  // Edge output style pulses only on the rise of pend_any.
  always_comb begin
    irq_set = (C_IRQ_SENSITIVITY != 0) ? pend_any : (pend_any & ~pend_q);
    irq_d   = irq_set ? IrqActive : ~IrqActive;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      gie_q     <= 1'b0;
      ier_q     <= '0;
      mode_q    <= '0;
      rdata_q   <= '0;
      pend_q    <= 1'b0;
      irq_q     <= ~IrqActive;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      gie_q     <= gie_d;
      ier_q     <= ier_d;
      mode_q    <= mode_d;
      rdata_q   <= rdata_d;
      pend_q    <= pend_any;
      irq_q     <= irq_d;
    end
  end

  assign S_AXI_AWREADY = wr_en;
  assign S_AXI_WREADY  = wr_en;
  assign S_AXI_BVALID  = (w_state_q == WResp);
  assign S_AXI_BRESP   = RespOkay;
  assign S_AXI_ARREADY = rd_en;
  assign S_AXI_RVALID  = (r_state_q == RData);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RespOkay;
  assign irq           = irq_q;

  assign unused_sigs = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWPROT, S_AXI_ARPROT,
                         gie_wr, ier_wr, mode_wr, clr_wr};

endmodule

// File: tb/tb_axi_lite_intr_ctrl.sv
// Self-checking bench: directed test-plan steps then random traffic against a behavioural model.
module tb_axi_lite_intr_ctrl;

  localparam int N = 4;
  localparam logic [31:0] NMASK = 32'hF;
`ifdef INTR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] intr;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;

  logic l_awready, l_wready, l_bvalid, l_arready, l_rvalid, l_irq;
  logic e_awready, e_wready, e_bvalid, e_arready, e_rvalid, e_irq;
  logic [1:0]  l_bresp, l_rresp, e_bresp, e_rresp;
  logic [31:0] l_rdata, e_rdata;

  // Level output, active-high.
  axi_lite_intr_ctrl #(
    .C_NUM_INTR(N), .C_S_AXI_ADDR_WIDTH(5), .C_IRQ_SENSITIVITY(1), .C_IRQ_ACTIVE_STATE(1)
  ) u_lvl (
    .ACLK(clk), .ARESETN(rst_n), .intr(intr),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(l_awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(l_wready), .S_AXI_BRESP(l_bresp),
    .S_AXI_BVALID(l_bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(l_arready),
    .S_AXI_RDATA(l_rdata), .S_AXI_RRESP(l_rresp), .S_AXI_RVALID(l_rvalid),
    .S_AXI_RREADY(rready), .irq(l_irq)
  );

  // Edge (pulse) output, active-low.
  axi_lite_intr_ctrl #(
    .C_NUM_INTR(N), .C_S_AXI_ADDR_WIDTH(5), .C_IRQ_SENSITIVITY(0), .C_IRQ_ACTIVE_STATE(0)
  ) u_edg (
    .ACLK(clk), .ARESETN(rst_n), .intr(intr),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(e_awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(e_wready), .S_AXI_BRESP(e_bresp),
    .S_AXI_BVALID(e_bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(e_arready),
    .S_AXI_RDATA(e_rdata), .S_AXI_RRESP(e_rresp), .S_AXI_RVALID(e_rvalid),
    .S_AXI_RREADY(rready), .irq(e_irq)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  logic        m_gie, m_bvalid, m_rvalid, m_pend_prev, m_irq_lvl, m_irq_pulse, m_wacc, m_pend;
  logic [31:0] m_ier, m_mode, m_isr, m_rdata, m_wm, m_src, m_rise, m_set, m_clr;
  logic [31:0] m_hist, m_sync1, m_sync2;

  function automatic logic [31:0] reg_val(logic [4:0] a);
    case (a[4:2])
      3'd0:    return {31'b0, m_gie};
      3'd1:    return m_ier;
      3'd2:    return m_isr;
      3'd4:    return m_isr & m_ier;
      3'd5:    return m_mode;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return (o & ~m) | (n & m);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_gie = 0; m_ier = 0; m_mode = 0; m_isr = 0; m_rdata = 0;
        m_bvalid = 0; m_rvalid = 0; m_pend_prev = 0; m_irq_lvl = 0; m_irq_pulse = 0;
        m_hist = 0; m_sync1 = 0; m_sync2 = 0;
      end else begin
        m_pend      = m_gie && ((m_isr & m_ier) != 0);
        m_irq_lvl   = m_pend;
        m_irq_pulse = m_pend && !m_pend_prev;
        m_pend_prev = m_pend;
        if (!m_rvalid && arvalid) begin
          m_rdata = reg_val(araddr); m_rvalid = 1;
        end else if (m_rvalid && rready) begin
          m_rvalid = 0;
        end
        m_wacc = !m_bvalid && awvalid && wvalid;
        m_wm   = merge(reg_val(awaddr), wdata, wstrb) & NMASK;
        m_src  = (LAT == 1) ? 32'(intr) : m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = 32'(intr);
        m_rise = m_src & ~m_hist;
        m_set  = (m_rise & m_mode) | (m_src & ~m_mode);
        m_clr  = (m_wacc && awaddr[4:2] == 3'd3) ? m_wm : 32'h0;
        m_isr  = m_set | (m_isr & ~m_clr);
        m_hist = m_src;
        if (m_wacc) begin
          case (awaddr[4:2])
            3'd0:    m_gie  = m_wm[0];
            3'd1:    m_ier  = m_wm;
            3'd5:    m_mode = m_wm;
            default: ;
          endcase
          m_bvalid = 1;
        end else if (m_bvalid && bready) begin
          m_bvalid = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("irq_lvl", {31'b0, l_irq}, {31'b0, m_irq_lvl});
    chk("irq_edge", {31'b0, e_irq}, m_irq_pulse ? 32'd0 : 32'd1);
    chk("bvalid", {30'b0, e_bvalid, l_bvalid}, m_bvalid ? 32'd3 : 32'd0);
    chk("rvalid", {30'b0, e_rvalid, l_rvalid}, m_rvalid ? 32'd3 : 32'd0);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    #1;
    chk("awready", {29'b0, e_awready, l_wready, l_awready}, m_bvalid ? 32'd0 : 32'd7);
    tick();
    awvalid = 0; wvalid = 0;
    chk("bresp", {28'b0, e_bresp, l_bresp}, 32'd0);
    tick();
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    araddr = a; arvalid = 1; rready = 1;
    #1;
    chk("arready", {30'b0, e_arready, l_arready}, m_rvalid ? 32'd0 : 32'd3);
    tick();
    arvalid = 0;
    chk("rdata", l_rdata, m_rdata);
    chk("rdata_e", e_rdata, m_rdata);
    chk("rresp", {28'b0, e_rresp, l_rresp}, 32'd0);
    d = l_rdata;
    tick();
  endtask

  task automatic wr_rd(input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [4:0] ra);
    awaddr = wa; wdata = wd; wstrb = ws; awvalid = 1; wvalid = 1;
    araddr = ra; arvalid = 1; rready = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("wr_rd_rdata", l_rdata, m_rdata);
    tick();
  endtask

  initial begin
    logic [31:0] d;
    int pulses;
    rst_n = 0; intr = '0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 1; arvalid = 0; rready = 1;
    repeat (3) tick();
    chk("rst_irq_lvl", {31'b0, l_irq}, 32'd0);
    chk("rst_irq_edge", {31'b0, e_irq}, 32'd1);
    rst_n = 1;
    tick();
    for (int a = 0; a < 6; a++) begin
      axi_read(5'(a * 4), d);
      chk("rst_reg", d, 32'h0);
    end

    // Edge capture with level output.
    axi_write(5'h14, 32'hF, 4'hF);
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h5, 4'hF);
    intr[2] = 1; tick(); intr[2] = 0;
    repeat (LAT + 2) tick();
    axi_read(5'h10, d); chk("edge_ipr", d, 32'h4);
    chk("edge_irq", {31'b0, l_irq}, 32'd1);
    axi_write(5'h0C, 32'h4, 4'hF);
    axi_read(5'h10, d); chk("ack_ipr", d, 32'h0);
    chk("ack_irq", {31'b0, l_irq}, 32'd0);

    // Level capture: clear ignored while input high.
    axi_write(5'h14, 32'h0, 4'hF);
    intr[1] = 1;
    axi_write(5'h04, 32'h2, 4'hF);
    axi_write(5'h0C, 32'h2, 4'hF);
    axi_read(5'h08, d); chk("lvl_hold_isr", d, 32'h2);
    intr[1] = 0;
    repeat (LAT + 1) tick();
    axi_write(5'h0C, 32'h2, 4'hF);
    axi_read(5'h08, d); chk("lvl_clr_isr", d, 32'h0);

    // Masking by IER and GIE.
    axi_write(5'h04, 32'h0, 4'hF);
    intr[0] = 1; tick(); intr[0] = 0;
    repeat (LAT + 2) tick();
    axi_read(5'h08, d); chk("mask_isr", d, 32'h1);
    axi_read(5'h10, d); chk("mask_ipr", d, 32'h0);
    chk("mask_irq", {31'b0, l_irq}, 32'd0);
    axi_write(5'h00, 32'h0, 4'hF);
    axi_write(5'h04, 32'h1, 4'hF);
    repeat (3) tick();
    chk("gie_off_irq", {31'b0, l_irq}, 32'd0);
    axi_write(5'h00, 32'h1, 4'hF);
    repeat (2) tick();
    chk("gie_on_irq", {31'b0, l_irq}, 32'd1);
    axi_write(5'h0C, 32'h1, 4'hF);

    // Edge output: two sources 5 cycles apart give a single pulse.
    axi_write(5'h14, 32'hF, 4'hF);
    axi_write(5'h04, 32'hF, 4'hF);
    pulses = 0;
    intr[0] = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (e_irq === 1'b0) pulses++;
      intr[0] = 0;
      if (i == 4) intr[3] = 1;
      if (i == 5) intr[3] = 0;
    end
    chk("edge_pulses", 32'(pulses), 32'd1);

    // Set and clear on the same edge: set wins.
    axi_write(5'h0C, 32'h8, 4'hF);
    intr[0] = 1;
    repeat (LAT - 1) tick();
    axi_write(5'h0C, 32'h1, 4'hF);
    axi_read(5'h08, d); chk("race_isr", d, 32'h1);
    intr[0] = 0;
    axi_write(5'h0C, 32'h1, 4'hF);
    axi_read(5'h08, d); chk("race_clr", d, 32'h0);

    // BREADY held low blocks a second write.
    bready = 0;
    awaddr = 5'h14; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    #1 chk("bp_first_acc", {31'b0, l_awready}, 32'd1);
    tick();
    wdata = 32'hC;
    for (int i = 0; i < 10; i++) begin
      #1 chk("bp_no_acc", {31'b0, l_awready}, 32'd0);
      tick();
      chk("bp_bvalid", {31'b0, l_bvalid}, 32'd1);
    end
    bready = 1;
    tick();
    #1 chk("bp_second_acc", {31'b0, l_awready}, 32'd1);
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    axi_read(5'h14, d); chk("bp_mode", d, 32'hC);

    // Reset mid-transaction drops all handshakes.
    bready = 0; rready = 0;
    awaddr = 5'h04; wdata = 32'h7; awvalid = 1; wvalid = 1; araddr = 5'h04; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    rst_n = 0;
    #1 chk("rst_mid_hs", {29'b0, l_bvalid, l_rvalid, l_awready}, 32'd0);
    tick();
    bready = 1; rready = 1; rst_n = 1;
    tick();
    axi_read(5'h04, d); chk("rst_mid_ier", d, 32'h0);

    // Random traffic against the model.
    for (int it = 0; it < 200; it++) begin
      int op;
      intr = 4'($urandom);
      op = $urandom_range(0, 4);
      case (op)
        0: axi_write(5'($urandom_range(0, 7) * 4), $urandom, 4'($urandom));
        1: axi_write(5'($urandom_range(0, 5) * 4), $urandom, 4'hF);
        2: axi_read(5'($urandom_range(0, 7) * 4), d);
        3: wr_rd(5'($urandom_range(0, 5) * 4), $urandom, 4'hF, 5'($urandom_range(0, 5) * 4));
        default: repeat ($urandom_range(1, 3)) tick();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
